// File: rtl/ycr1_ahb_slave_pkg.sv
// Shared types, AHB encodings and helpers for the AHB-Lite SRAM responder.
package ycr1_ahb_slave_pkg;

  localparam logic [1:0] YCR1_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] YCR1_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] YCR1_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] YCR1_HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] YCR1_HSIZE_8BIT  = 3'b000;
  localparam logic [2:0] YCR1_HSIZE_16BIT = 3'b001;
  localparam logic [2:0] YCR1_HSIZE_32BIT = 3'b010;

  localparam logic YCR1_HRESP_OKAY  = 1'b0;
  localparam logic YCR1_HRESP_ERROR = 1'b1;

  // Data-phase state of the responder
  typedef enum logic [2:0] {
    YCR1_AHBS_IDLE,
    YCR1_AHBS_RD,
    YCR1_AHBS_WR,
    YCR1_AHBS_ERR1,
    YCR1_AHBS_ERR2
  } type_ycr1_ahbs_fsm_e;

  // Posted-write entry; addr is a zero-extended SRAM word address
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } type_ycr1_wbuf_s;

  // Byte-lane write mask for an aligned transfer
  function automatic logic [3:0] ycr1_ahbs_wmask(input logic [2:0] hsize,
                                                 input logic [1:0] addr_lo);
    logic [3:0] m;
    case (hsize)
      YCR1_HSIZE_8BIT:  m = 4'b0001 << addr_lo;
      YCR1_HSIZE_16BIT: m = 4'b0011 << {addr_lo[1], 1'b0};
      default:          m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ycr1_ahbs_wbuf.sv
// One-entry posted write buffer: capture, commit to SRAM, and read-side byte merge.
module ycr1_ahbs_wbuf
  import ycr1_ahb_slave_pkg::*;
#(
  parameter int SRAM_AW = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture,
  input  logic                 commit,
  input  type_ycr1_wbuf_s      cap_entry,
  input  logic [SRAM_AW-1:0]   rd_addr,
  input  logic [31:0]          sram_rdata,
  output logic                 valid,
  output logic [SRAM_AW-1:0]   cm_addr,
  output logic [3:0]           cm_mask,
  output logic [31:0]          cm_data,
  output logic [31:0]          rd_merged
);

  type_ycr1_wbuf_s entry;
  logic            hit;

  function automatic logic [31:0] byte_merge(input logic [31:0] base,
                                             input logic [31:0] upd,
                                             input logic [3:0]  m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = m[b] ? upd[8*b +: 8] : base[8*b +: 8];
    end
    return r;
  endfunction

  // Occupancy: a capture in the same cycle as a commit leaves the new entry valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
    end else if (commit) begin
      valid <= 1'b0;
    end
  end

  // Entry payload is pure data and carries no reset
  always_ff @(posedge clk) begin
    if (capture) begin
      entry <= cap_entry;
    end
  end

  assign hit       = valid && (entry.addr == 30'(rd_addr));
  assign rd_merged = hit ? byte_merge(sram_rdata, entry.data, entry.mask) : sram_rdata;
  assign cm_addr   = entry.addr[SRAM_AW-1:0];
  assign cm_mask   = entry.mask;
  assign cm_data   = entry.data;

endmodule

// File: rtl/ycr1_ahb_sram_slave.sv
// AHB-Lite responder for a single-port synchronous SRAM: zero-wait reads,
// posted writes through a one-entry buffer, two-cycle ERROR on illegal transfers.
module ycr1_ahb_sram_slave
  import ycr1_ahb_slave_pkg::*;
#(
  parameter int SRAM_AW   = 9,
  parameter int AHB_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [AHB_WIDTH-1:0]  haddr,
  input  logic [AHB_WIDTH-1:0]  hwdata,
  input  logic                  hready_in,
  output logic                  hready,
  output logic                  hresp,
  output logic [AHB_WIDTH-1:0]  hrdata,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [3:0]            sram_wmask,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  type_ycr1_ahbs_fsm_e state, state_next;

  logic               xfer, misalign, bad_size, out_of_range, addr_err;
  logic               rd_req, wr_req, err_req;
  logic               wr_active, direct_wr, capture, commit;
  logic [SRAM_AW-1:0] rd_addr_q, wr_addr_q;
  logic [3:0]         wr_mask_q;
  logic               buf_valid;
  logic [SRAM_AW-1:0] cm_addr;
  logic [3:0]         cm_mask;
  logic [31:0]        cm_data, rd_merged;
  type_ycr1_wbuf_s    cap_entry;

  // Address-phase decode
  assign xfer = hsel & hready_in & hready &
                ((htrans == YCR1_HTRANS_NONSEQ) | (htrans == YCR1_HTRANS_SEQ));
  assign bad_size     = (hsize > YCR1_HSIZE_32BIT);
  assign out_of_range = |haddr[AHB_WIDTH-1:SRAM_AW+2];

  // Alignment check for the transfer size
  always_comb begin
    misalign = 1'b0;
    case (hsize)
      YCR1_HSIZE_16BIT: misalign = haddr[0];
      YCR1_HSIZE_32BIT: misalign = |haddr[1:0];
      default:          misalign = 1'b0;
    endcase
  end

  assign addr_err = bad_size | misalign | out_of_range;
  assign rd_req   = xfer & ~hwrite & ~addr_err;
  assign wr_req   = xfer &  hwrite & ~addr_err;
  assign err_req  = xfer &  addr_err;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= YCR1_AHBS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: ERR1 always completes into ERR2; otherwise follow the accepted transfer
  always_comb begin
    state_next = state;
    case (state)
      YCR1_AHBS_ERR1: state_next = YCR1_AHBS_ERR2;
      default: begin
        if (hready_in) begin
          if (err_req)     state_next = YCR1_AHBS_ERR1;
          else if (rd_req) state_next = YCR1_AHBS_RD;
          else if (wr_req) state_next = YCR1_AHBS_WR;
          else             state_next = YCR1_AHBS_IDLE;
        end
      end
    endcase
  end

  assign hready = (state != YCR1_AHBS_ERR1);
  assign hresp  = ((state == YCR1_AHBS_ERR1) || (state == YCR1_AHBS_ERR2)) ?
                  YCR1_HRESP_ERROR : YCR1_HRESP_OKAY;

  // Address-phase attributes needed in the following data phase
  always_ff @(posedge clk) begin
    if (rd_req) begin
      rd_addr_q <= haddr[SRAM_AW+1:2];
    end
    if (wr_req) begin
      wr_addr_q <= haddr[SRAM_AW+1:2];
      wr_mask_q <= ycr1_ahbs_wmask(hsize, haddr[1:0]);
    end
  end

  // A read address phase owns the SRAM; a write goes straight in only when
  // nothing is buffered, otherwise it is posted. Idle SRAM cycles drain the buffer.
  assign wr_active = (state == YCR1_AHBS_WR) & hready_in;
  assign direct_wr = wr_active & ~rd_req & ~buf_valid;
  assign capture   = wr_active & ~direct_wr;
  assign commit    = buf_valid & ~rd_req & ~direct_wr;

  assign cap_entry.addr = 30'(wr_addr_q);
  assign cap_entry.mask = wr_mask_q;
  assign cap_entry.data = hwdata[31:0];

  ycr1_ahbs_wbuf #(.SRAM_AW(SRAM_AW)) i_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (capture),
    .commit     (commit),
    .cap_entry  (cap_entry),
    .rd_addr    (rd_addr_q),
    .sram_rdata (sram_rdata),
    .valid      (buf_valid),
    .cm_addr    (cm_addr),
    .cm_mask    (cm_mask),
    .cm_data    (cm_data),
    .rd_merged  (rd_merged)
  );

  // SRAM port arbitration: read, then direct write, then buffer commit
  always_comb begin
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (rd_req) begin
      sram_csb  = 1'b0;
      sram_addr = haddr[SRAM_AW+1:2];
    end else if (direct_wr) begin
      sram_csb   = 1'b0;
      sram_web   = 1'b0;
      sram_addr  = wr_addr_q;
      sram_wmask = wr_mask_q;
      sram_wdata = hwdata[31:0];
    end else if (commit) begin
      sram_csb   = 1'b0;
      sram_web   = 1'b0;
      sram_addr  = cm_addr;
      sram_wmask = cm_mask;
      sram_wdata = cm_data;
    end
  end

  assign hrdata = (state == YCR1_AHBS_RD) ? AHB_WIDTH'(rd_merged) : '0;

endmodule
